vga_scan_gen: RTL and testbench
===============================

Name: vga_scan_gen

Overview:
- Generates VGA raster timing: horizontal/vertical counters, sync pulses, active-video flag.
- Produces a linear 19-bit frame-buffer pixel address together with a load strobe, which feed the 19-bit pixel-address register (data_in / en) in front of frame-buffer memory.
- The address is built incrementally; no multiplier.
- Default timing is 640x480 at 60 Hz, advancing one pixel per cycle in which pix_en is high.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous reset, active-low (0 = reset)
- pix_en  in  1  pixel tick; all state advances only on clk rising edges where pix_en=1
- h_cnt  out  10  current column, 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800)
- v_cnt  out  10  current line, 0..V_TOTAL-1 (V_TOTAL = sum of V_* = 525)
- hsync_n  out  1  horizontal sync, active-low
- vsync_n  out  1  vertical sync, active-low
- active  out  1  1 when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
- pix_addr  out  19  linear address of the current pixel, v_cnt*H_ACTIVE + h_cnt, while active=1
- addr_ld  out  1  load strobe for the address register; equals active & pix_en
- frame_start  out  1  one-cycle pulse on the tick that wraps to (0,0)

Behaviour:
- Reset (clr=0, asynchronous): h_cnt=0, v_cnt=0, pix_addr=0, hsync_n=1, vsync_n=1, frame_start=0.
- Reset consequences: active=1 while in reset, since (0,0) is visible. addr_ld follows pix_en.
- Release: on the first tick the counters advance to (1,0) and pix_addr to 1.
- Registered state: h_cnt, v_cnt, pix_addr, hsync_n, vsync_n, frame_start.
- Combinational outputs: active and addr_ld, decoded from registered state only.
- Registered sync outputs are computed from next-state counter values, so they are aligned with h_cnt/v_cnt. No skew between them.
- pix_en=0: every register holds; frame_start is forced to 0 on that edge.
- Horizontal counter: increments per tick; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
- Vertical counter: at V_TOTAL-1 together with h_cnt=H_TOTAL-1, v_cnt wraps to 0.
- hsync_n=0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751 at defaults.
- vsync_n=0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. lines 490..491, for the whole line.
- pix_addr increments by 1 on each tick taken while active=1.
- pix_addr holds on ticks taken while active=0.
- pix_addr resets to 0 on the frame-wrap tick.
- pix_addr during horizontal blanking equals the address of the next line's first pixel, e.g. 640 after line 0.
- After the last visible pixel (639,479) pix_addr=307200 and holds until the frame wrap. This value fits in 19 bits; the max encodable value is 524287, so no overflow is possible.
- frame_start=1 for exactly one tick-cycle when the state becomes (0,0) through a wrap. It is 0 out of reset.
- Simultaneous h and v wrap: handled in a single edge.
  - v_cnt goes to 0, pix_addr goes to 0, frame_start goes to 1.
  - vsync_n and hsync_n are both 1 at (0,0).
- Reset mid-frame: counters and address return to their reset values immediately. No partial-line completion.
- Parameter rule: H_TOTAL<=1024, V_TOTAL<=1024, H_ACTIVE*V_ACTIVE<=2^19-1. This is checked at elaboration.

Test Plan:
- Reset then pix_en=1 constantly: h_cnt counts 0..799 then 0, v_cnt becomes 1 at cycle 800, and pix_addr=640 at (0,1).
- hsync_n=0 exactly for h_cnt 656..751 on every line. vsync_n=0 for exactly 1600 ticks, covering lines 490 and 491.
- Full frame: pix_addr=307199 at (639,479) with active=1. At (640,479) active=0 and pix_addr=307200. After 420000 ticks the state is (0,0) with pix_addr=0 and frame_start=1 for one cycle.
- pix_en toggling 1,0,1,0: counters and pix_addr advance only on pix_en=1 edges. addr_ld=0 whenever pix_en=0. frame_start never stretches.
- clr driven to 0 asynchronously at (300,200), pix_addr=128300: all outputs return to reset values without waiting for a clk edge. After release the count restarts from (0,0).
- Small-parameter build (H_ACTIVE=4, each porch/sync=1, V_ACTIVE=3, each porch/sync=1): exhaustive comparison of h_cnt, v_cnt, syncs, active and pix_addr against a reference model over 3 frames.

Source files
------------

// File: rtl/vga_scan_gen.sv
// ----------------------------------------------------------------------------
// vga_scan_gen
//   VGA raster timing generator. Keeps horizontal/vertical position counters,
//   produces active-low sync pulses and an active-video flag, and builds the
//   linear frame-buffer pixel address (v_cnt*H_ACTIVE + h_cnt) incrementally,
//   together with a load strobe for the downstream pixel-address register.
//
// Ports
//   clk          in   system clock
//   clr          in   asynchronous reset, active-low
//   pix_en       in   pixel tick; state advances only on edges with pix_en=1
//   h_cnt        out  [9:0]  current column, 0..H_TOTAL-1
//   v_cnt        out  [9:0]  current line, 0..V_TOTAL-1
//   hsync_n      out  horizontal sync, active-low
//   vsync_n      out  vertical sync, active-low
//   active       out  visible-area flag (combinational from registered state)
//   pix_addr     out  [18:0] linear address of the current pixel
//   addr_ld      out  address-register load strobe, active & pix_en
//   frame_start  out  one tick-cycle pulse when the raster wraps to (0,0)
// ----------------------------------------------------------------------------
module vga_scan_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        pix_en,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        active,
    output logic [18:0] pix_addr,
    output logic        addr_ld,
    output logic        frame_start
);

    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int H_SYNC_HI = H_SYNC_LO + H_SYNC;
    localparam int V_SYNC_LO = V_ACTIVE + V_FP;
    localparam int V_SYNC_HI = V_SYNC_LO + V_SYNC;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_ACTIVE < 1 || V_ACTIVE < 1 ||
            H_ACTIVE * V_ACTIVE > 524287) begin : g_param_check
            $error("vga_scan_gen: timing parameters out of range");
        end
    endgenerate

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [18:0] pix_addr_q, pix_addr_d;
    logic        hsync_n_q, hsync_n_d;
    logic        vsync_n_q, vsync_n_d;
    logic        frame_start_q, frame_start_d;

    logic h_last, v_last, frame_wrap, active_w;

    always_comb begin
        h_last     = (h_cnt_q == 10'(H_TOTAL - 1));
        v_last     = (v_cnt_q == 10'(V_TOTAL - 1));
        frame_wrap = h_last & v_last;
        // 11-bit compares so a 1024-wide active region still decodes correctly
        active_w   = ({1'b0, h_cnt_q} < 11'(H_ACTIVE)) &&
                     ({1'b0, v_cnt_q} < 11'(V_ACTIVE));

        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        pix_addr_d    = pix_addr_q;
        frame_start_d = 1'b0;

        if (pix_en) begin
            h_cnt_d = h_last ? 10'd0 : h_cnt_q + 10'd1;
            if (h_last) begin
                v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
            end
            // The address only moves past visible pixels, so during blanking it
            // already points at the first pixel of the next visible line.
            if (frame_wrap) begin
                pix_addr_d = 19'd0;
            end else if (active_w) begin
                pix_addr_d = pix_addr_q + 19'd1;
            end
            frame_start_d = frame_wrap;
        end

        // Syncs decode the next-state counters so they register in step with them.
        hsync_n_d = !(({1'b0, h_cnt_d} >= 11'(H_SYNC_LO)) &&
                      ({1'b0, h_cnt_d} <  11'(H_SYNC_HI)));
        vsync_n_d = !(({1'b0, v_cnt_d} >= 11'(V_SYNC_LO)) &&
                      ({1'b0, v_cnt_d} <  11'(V_SYNC_HI)));
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            pix_addr_q    <= 19'd0;
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            pix_addr_q    <= pix_addr_d;
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_cnt       = h_cnt_q;
    assign v_cnt       = v_cnt_q;
    assign pix_addr    = pix_addr_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign frame_start = frame_start_q;
    assign active      = active_w;
    assign addr_ld     = active_w & pix_en;

endmodule

// File: tb/tb_vga_scan_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_scan_gen
//   Drives a default-timing instance and a tiny-timing instance from the same
//   clock, reset and pixel tick. The reference derives the expected raster
//   position, syncs, address and frame pulse from the number of ticks taken
//   since reset, using plain division/modulo on the timing parameters.
// ----------------------------------------------------------------------------
module tb_vga_scan_gen;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic pix_en = 1'b0;

    logic [9:0]  h_b, v_b, h_s, v_s;
    logic        hs_b, vs_b, act_b, ld_b, fs_b;
    logic        hs_s, vs_s, act_s, ld_s, fs_s;
    logic [18:0] a_b, a_s;

    int checks = 0;
    int errors = 0;
    int t      = 0;     // ticks taken since reset release
    bit ticked = 1'b0;  // last rising edge was a taken tick

    always #5 clk = ~clk;

    vga_scan_gen u_big (
        .clk(clk), .clr(clr), .pix_en(pix_en),
        .h_cnt(h_b), .v_cnt(v_b), .hsync_n(hs_b), .vsync_n(vs_b),
        .active(act_b), .pix_addr(a_b), .addr_ld(ld_b), .frame_start(fs_b)
    );

    vga_scan_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_sml (
        .clk(clk), .clr(clr), .pix_en(pix_en),
        .h_cnt(h_s), .v_cnt(v_s), .hsync_n(hs_s), .vsync_n(vs_s),
        .active(act_s), .pix_addr(a_s), .addr_ld(ld_s), .frame_start(fs_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_dut(input string nm,
                             input int ha, input int hf, input int hsw, input int hb,
                             input int va, input int vf, input int vsw, input int vb,
                             input logic [9:0] h_o, input logic [9:0] v_o,
                             input logic hs_o, input logic vs_o, input logic act_o,
                             input logic [18:0] a_o, input logic ld_o, input logic fs_o);
        int ht, vt, pos, eh, ev, ea;
        logic e_act, e_hs, e_vs, e_fs;
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        pos = t % (ht * vt);
        eh  = pos % ht;
        ev  = pos / ht;
        if (ev >= va)      ea = ha * va;
        else if (eh < ha)  ea = ev * ha + eh;
        else               ea = (ev + 1) * ha;
        e_act = (eh < ha) && (ev < va);
        e_hs  = !((eh >= ha + hf) && (eh < ha + hf + hsw));
        e_vs  = !((ev >= va + vf) && (ev < va + vf + vsw));
        e_fs  = ticked && (t > 0) && (pos == 0);
        check($sformatf("%s_h_cnt t=%0d", nm, t),    32'(h_o),   32'(eh));
        check($sformatf("%s_v_cnt t=%0d", nm, t),    32'(v_o),   32'(ev));
        check($sformatf("%s_hsync_n t=%0d", nm, t),  32'(hs_o),  32'(e_hs));
        check($sformatf("%s_vsync_n t=%0d", nm, t),  32'(vs_o),  32'(e_vs));
        check($sformatf("%s_active t=%0d", nm, t),   32'(act_o), 32'(e_act));
        check($sformatf("%s_pix_addr t=%0d", nm, t), 32'(a_o),   32'(ea));
        check($sformatf("%s_addr_ld t=%0d", nm, t),  32'(ld_o),  32'(e_act & pix_en));
        check($sformatf("%s_frame_start t=%0d", nm, t), 32'(fs_o), 32'(e_fs));
    endtask

    task automatic check_all();
        check_dut("big", 640, 16, 96, 48, 480, 10, 2, 33,
                  h_b, v_b, hs_b, vs_b, act_b, a_b, ld_b, fs_b);
        check_dut("sml", 4, 1, 1, 1, 3, 1, 1, 1,
                  h_s, v_s, hs_s, vs_s, act_s, a_s, ld_s, fs_s);
    endtask

    // Drive pix_en away from the edge, update the reference at the edge,
    // compare on the falling edge.
    task automatic cycle(input logic pe);
        pix_en = pe;
        @(posedge clk);
        if (clr) begin
            if (pe) t++;
            ticked = pe;
        end else begin
            t      = 0;
            ticked = 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic async_reset();
        #2 clr = 1'b0;
        t      = 0;
        ticked = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        #1 clr = 1'b0;
        @(negedge clk);
        check_all();
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        clr = 1'b1;

        for (int i = 0; i < 900; i++) begin
            cycle(1'b1);
            if (t == 1) begin
                check("first_tick_h", 32'(h_b), 32'd1);
                check("first_tick_addr", 32'(a_b), 32'd1);
            end
            if (t == 639) check("last_pix_line0_addr", 32'(a_b), 32'd639);
            if (t == 640) begin
                check("hblank_active", 32'(act_b), 32'd0);
                check("hblank_addr", 32'(a_b), 32'd640);
            end
            if (t == 656) check("hsync_start", 32'(hs_b), 32'd0);
            if (t == 752) check("hsync_end", 32'(hs_b), 32'd1);
            if (t == 800) begin
                check("line1_v", 32'(v_b), 32'd1);
                check("line1_h", 32'(h_b), 32'd0);
                check("line1_addr", 32'(a_b), 32'd640);
            end
        end

        for (int i = 0; i < 200; i++) begin
            cycle((i % 2) == 0);
        end

        for (int i = 0; i < 1600; i++) begin
            cycle($urandom_range(0, 3) != 0);
        end

        async_reset();
        check("async_rst_h", 32'(h_b), 32'd0);
        check("async_rst_addr", 32'(a_b), 32'd0);
        cycle(1'b1);
        cycle(1'b0);
        clr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
